// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for a 5-stage RV32I pipeline: stage enables and flushes,
// EX forwarding selects, Dmem request handshake with timeout, saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_w_ctrl,
  input  logic             ex_is_load,
  input  logic             c,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_w_ctrl,
  input  logic             mem_ld_st,
  input  logic             dmem_ack,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_w_ctrl,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             dmem_req,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;
  localparam int         WC_W        = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [0:0]       state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Bit order: en = {pc, if_id, id_ex, ex_mem, mem_wb}, fl = {if_id, id_ex, ex_mem, mem_wb}
  logic [4:0] en_raw, en;
  logic [3:0] fl;
  logic       load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] m_rd, input logic m_wn,
                                         input logic [4:0] w_rd, input logic w_wn);
    if (!m_wn && m_rd != 5'd0 && m_rd == rs)      return 2'b01;
    else if (!w_wn && w_rd != 5'd0 && w_rd == rs) return 2'b10;
    else                                          return 2'b00;
  endfunction

  assign load_use = ex_is_load & ~ex_reg_w_ctrl & (ex_rd != 5'd0) &
                    ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    en_raw     = 5'b11111;
    fl         = 4'b0000;

    case (state_q)
      ST_RUN: begin
        if (mem_ld_st && !dmem_ack) begin
          en_raw     = 5'b00000;
          fl[0]      = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end else if (c) begin
          fl[3:2] = 2'b11;
        end else if (load_use) begin
          en_raw[4:3] = 2'b00;
          fl[2]       = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        en_raw = 5'b00000;
        fl[0]  = 1'b1;
        if (dmem_ack) begin
          // Release everything; redirects and load-use are reconsidered next cycle.
          en_raw     = 5'b11111;
          fl         = 4'b0000;
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT)) begin
          fl[1]      = 1'b1;
          mem_err_d  = 1'b1;
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase

    if (!rst_n) begin
      en_raw = 5'b00000;
      fl     = 4'b1111;
    end

    // A flushed register loads the bubble, so its plain enable is suppressed.
    en = en_raw & ~{1'b0, fl};

    stall_cnt_d = stall_cnt_q;
    if (!en[4] && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset lives inside the clocked block; state uses non-blocking only.
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}     = en;
  assign {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = fl;

  assign dmem_req  = rst_n & mem_ld_st;
  assign fwd_a_sel = rst_n ? fwd_sel(ex_rs1, mem_rd, mem_reg_w_ctrl, wb_rd, wb_reg_w_ctrl) : 2'b00;
  assign fwd_b_sel = rst_n ? fwd_sel(ex_rs2, mem_rd, mem_reg_w_ctrl, wb_rd, wb_reg_w_ctrl) : 2'b00;
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule
